// File: rtl/fft_readout_if.sv
// Output stream bundle for fft_readout: one magnitude beat per bin with a
// valid/ready handshake. The master drives the beat, the slave drives ready.
interface fft_readout_if #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 9
);
  logic                   valid;
  logic                   ready;
  logic [2*BIT_WIDTH-1:0] mag;
  logic [N-2:0]           bin;
  logic                   last;

  modport master (output valid, output mag, output bin, output last, input ready);
  modport slave  (input valid, input mag, input bin, input last, output ready);
endinterface

// File: rtl/fft_readout.sv
// fft_readout: on a rising edge of fft_done, walks the lower half of the FFT
// result memory, squares each {re, im} sample into a magnitude, streams the
// magnitudes out through a small credit-controlled FIFO and reports the
// largest non-DC bin of the frame.
module fft_readout #(
  parameter int BIT_WIDTH  = 16,
  parameter int N          = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fft_done_i,
  output logic [N-1:0]           rd_addr_o,
  output logic                   rd_active_o,
  input  logic [2*BIT_WIDTH-1:0] fft_dout_i,
  fft_readout_if.master          out_if,
  output logic [N-2:0]           peak_bin_o,
  output logic [2*BIT_WIDTH-1:0] peak_mag_o,
  output logic                   frame_done_o,
  output logic                   overrun_o
);

  localparam int BW2 = 2 * BIT_WIDTH;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [N-2:0] LAST_BIN = {(N-1){1'b1}};

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t         state_q;
  logic           done_q;
  logic [N-2:0]   addr_q;
  logic           v0_q, v1_q;
  logic [N-2:0]   bin0_q, bin1_q;
  logic [BW2-1:0] mag1_q;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [N-2:0]   run_bin_q, peak_bin_q;
  logic [BW2-1:0] run_mag_q, peak_mag_q;
  logic           frame_done_q, overrun_q;

  // FIFO storage: {bin, mag}; contents are only visible while count_q != 0
  logic [N-2+BW2:0] mem [FIFO_DEPTH];

  logic                        rise;
  logic [CW:0]                 credit_used;
  logic                        issue;
  logic                        pop;
  logic                        pop_last;
  logic [N-2+BW2:0]            head_w;
  logic [N-2:0]                head_bin;
  logic signed [BIT_WIDTH-1:0] re_s, im_s;
  logic signed [BW2-1:0]       re_w, im_w, re_sq, im_sq;
  logic [BW2-1:0]              mag_d;

  assign rise = fft_done_i & ~done_q;

  // Everything already committed to the FIFO or still in the read/square
  // pipeline consumes a credit, so an issued address always has a slot.
  assign credit_used = {1'b0, count_q} + (CW+1)'(v0_q) + (CW+1)'(v1_q);
  assign issue       = (state_q == READ) && (credit_used < (CW+1)'(FIFO_DEPTH));

  assign head_w   = mem[rd_ptr_q];
  assign head_bin = head_w[BW2 +: N-1];
  assign pop      = out_if.valid & out_if.ready;
  assign pop_last = pop && (head_bin == LAST_BIN);

  assign out_if.valid = (count_q != '0);
  assign out_if.bin   = out_if.valid ? head_bin : '0;
  assign out_if.mag   = out_if.valid ? head_w[BW2-1:0] : '0;
  assign out_if.last  = out_if.valid && (head_bin == LAST_BIN);

  // Squares are formed at full width from sign-extended parts; the sum peaks
  // at 2^(2*BIT_WIDTH-1) for (-max, -max), which still fits unsigned.
  assign re_s  = fft_dout_i[BW2-1:BIT_WIDTH];
  assign im_s  = fft_dout_i[BIT_WIDTH-1:0];
  assign re_w  = BW2'(re_s);
  assign im_w  = BW2'(im_s);
  assign re_sq = re_w * re_w;
  assign im_sq = im_w * im_w;
  assign mag_d = $unsigned(re_sq) + $unsigned(im_sq);

  assign rd_addr_o    = {1'b0, addr_q};
  assign rd_active_o  = (state_q == READ) || (state_q == DRAIN);
  assign peak_bin_o   = peak_bin_q;
  assign peak_mag_o   = peak_mag_q;
  assign frame_done_o = frame_done_q;
  assign overrun_o    = overrun_q;

  // Frame control FSM: edge detect, address walk, running peak and results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      addr_q       <= '0;
      run_bin_q    <= '0;
      run_mag_q    <= '0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      done_q       <= fft_done_i;
      frame_done_q <= 1'b0;
      if (rise && (state_q != IDLE)) overrun_q <= 1'b1;
      // bins enter the FIFO in order, so strict '>' keeps the lower bin on ties
      if (v1_q && (bin1_q != '0) && (mag1_q > run_mag_q)) begin
        run_bin_q <= bin1_q;
        run_mag_q <= mag1_q;
      end
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q   <= READ;
            addr_q    <= '0;
            run_bin_q <= '0;
            run_mag_q <= '0;
          end
        end
        READ: begin
          if (issue) begin
            if (addr_q == LAST_BIN) state_q <= DRAIN;
            else                    addr_q  <= addr_q + 1'b1;
          end
        end
        DRAIN: begin
          // the last bin is the final beat, so its acceptance implies an
          // empty FIFO and an empty pipeline
          if (pop_last) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
            peak_bin_q   <= run_bin_q;
            peak_mag_q   <= run_mag_q;
          end
        end
        default: begin
          state_q <= IDLE;
          addr_q  <= '0;
        end
      endcase
    end
  end

  // Read-latency pipeline, squaring stage and FIFO pointers/occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      bin0_q   <= '0;
      bin1_q   <= '0;
      mag1_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      v0_q   <= issue;
      bin0_q <= addr_q;
      v1_q   <= v0_q;
      bin1_q <= bin0_q;
      if (v0_q) mag1_q <= mag_d;
      if (v1_q) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (v1_q && !pop)      count_q <= count_q + 1'b1;
      else if (!v1_q && pop) count_q <= count_q - 1'b1;
    end
  end

  // FIFO storage write; reads are gated by occupancy so no reset is needed
  always_ff @(posedge clk) begin
    if (v1_q) mem[wr_ptr_q] <= {bin1_q, mag1_q};
  end

endmodule

// File: doc/fft_readout.md
FFT_READOUT -- requirements
Module: fft_readout

Interface
REQ-001 Parameter BIT_WIDTH, default 16, meaning signed width of each real/imag component from the FFT core.
REQ-002 Parameter N, default 9, meaning FFT address bits (2^N points); readout covers bins 0..2^(N-1)-1.
REQ-003 Parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of two, >=4).
REQ-004 Port clk  in  1  single clock, all logic rising-edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset (reset=0 asserts).
REQ-006 Port fft_done  in  1  FFT core completion level; rising edge requests a readout frame.
REQ-007 Port rd_addr  out  N  bin address to FFT core read port.
REQ-008 Port rd_active  out  1  high while block owns the FFT address bus (external mux selects rd_addr).
REQ-009 Port fft_dout  in  2*BIT_WIDTH  {real, imag} from core, valid one cycle after rd_addr.
REQ-010 Port out_valid / out_ready  out / in  1 / 1  output stream handshake.
REQ-011 Port out_mag  out  2*BIT_WIDTH  unsigned re^2+im^2 of current bin.
REQ-012 Port out_bin  out  N-1  bin index of out_mag.
REQ-013 Port out_last  out  1  high with final bin (2^(N-1)-1).
REQ-014 Port peak_bin / peak_mag  out  N-1 / 2*BIT_WIDTH  largest non-DC bin of last completed frame.
REQ-015 Port frame_done  out  1  one-cycle pulse when last bin is accepted.
REQ-016 Port overrun  out  1  sticky flag, start request while busy.

Function
REQ-017 FSM states IDLE, READ, DRAIN, DONE; reset state IDLE.
REQ-018 fft_done registered once; rising edge detected in IDLE moves to READ next cycle.
REQ-019 READ: issue one address per cycle, 0 upward, only when (fifo_count + inflight) < FIFO_DEPTH; rd_addr holds when stalled.
REQ-020 READ -> DRAIN after address 2^(N-1)-1 issued; DRAIN -> DONE when inflight=0, FIFO empty, last beat accepted.
REQ-021 DONE lasts one cycle: frame_done=1, peak outputs updated, then IDLE.
REQ-022 rd_active=1 in READ and DRAIN, 0 otherwise; rd_addr MSB (bit N-1) always 0.
REQ-023 Pipeline: address cycle c, fft_dout sampled end of c+1 into product stage, FIFO written end of c+2; earliest out_valid in c+3.
REQ-024 Magnitude: sign-extended re*re + im*im, result unsigned 2*BIT_WIDTH bits, no saturation needed (max 2^(2*BIT_WIDTH-1)).
REQ-025 Beat transfers when out_valid & out_ready; out_mag/out_bin/out_last stable while out_valid & !out_ready.
REQ-026 Backpressure never drops or duplicates bins; output order strictly 0..2^(N-1)-1.
REQ-027 Peak: bins >=1 only; update on strictly greater mag; ties keep lower bin; running peak cleared at frame start.
REQ-028 peak_bin/peak_mag change only in DONE; hold otherwise.
REQ-029 fft_done rising edge outside IDLE: ignored, overrun set to 1 until reset.
REQ-030 fft_done held high across frames does not retrigger; new frame needs a fresh rising edge.

Reset
REQ-031 On reset=0, immediately: state IDLE, rd_addr=0, rd_active=0, out_valid=0, out_mag=0, out_bin=0, out_last=0, frame_done=0, overrun=0, peak_bin=0, peak_mag=0, FIFO empty, inflight=0, edge register 0.
REQ-032 Reset mid-frame abandons frame, no frame_done, peak outputs cleared; release leaves block in IDLE awaiting a new edge.

Verification
REQ-033 N=4, bins re=k, im=0 (k=0..7), out_ready=1 -> 8 beats, out_mag=k^2, out_last on bin 7, frame_done once, peak_bin=7, peak_mag=49.
REQ-034 Same data, out_ready toggling 1-of-3 cycles -> identical beat sequence, FIFO never exceeds 4, no rd_addr advance when credit exhausted.
REQ-035 Bin 3 = (-32768, -32768) -> out_mag=0x80000000, peak_bin=3.
REQ-036 Bins 2 and 5 both mag 100, rest 0 -> peak_bin=2; DC mag 1000 ignored for peak.
REQ-037 Second fft_done edge during READ -> overrun=1, frame completes unaffected, no second frame.
REQ-038 reset=0 asserted at bin 3 of READ -> all outputs zero same cycle, no frame_done; new edge after release gives full correct frame.
